// File: rtl/steer_en_gen2_if.sv
// steer_en_gen2_if: load-cell sample bus and steering-enable status outputs
// of the steering-enable controller. The master drives samples and the slave
// (the controller) drives the status outputs.
interface steer_en_gen2_if #(
    parameter int unsigned LC_W = 12
);
    logic [LC_W-1:0] lft_ld;
    logic [LC_W-1:0] rght_ld;
    logic            ld_vld;
    logic            en_steer;
    logic            rider_off;
    logic [1:0]      state_o;

    modport master (
        output lft_ld, rght_ld, ld_vld,
        input  en_steer, rider_off, state_o
    );

    modport slave (
        input  lft_ld, rght_ld, ld_vld,
        output en_steer, rider_off, state_o
    );
endinterface

// File: rtl/steer_en_gen2.sv
// steer_en_gen2: second-generation steering-enable controller.
// Captures left/right load-cell samples and derives the rider weight and the
// imbalance. It also owns the stabilise timer and runs the
// INITIAL/STABILIZE/STEERING_EN state machine.
// Optional build macro STEER_OFF_DEB_EN: debounces the step-off condition
// over OFF_DEB_SMPLS consecutive samples while in STEERING_EN.
module steer_en_gen2 #(
    parameter int unsigned     LC_W          = 12,
    parameter logic [LC_W-1:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [LC_W-1:0] WT_HYST       = 12'h040,
    parameter int unsigned     TMR_W         = 26,
    parameter logic [TMR_W-1:0] TMR_FULL_CNT = 26'd65_000_000,
    parameter int unsigned     OFF_DEB_SMPLS = 4
) (
    input logic             clk,
    input logic             rst_n,
    steer_en_gen2_if.slave  sif
);

    typedef enum logic [1:0] {
        ST_INITIAL     = 2'b00,
        ST_STABILIZE   = 2'b01,
        ST_STEERING_EN = 2'b10
    } state_t;

    localparam logic [LC_W:0] SUM_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
    localparam logic [LC_W:0] SUM_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    // Out-of-range debounce lengths leave an empty marker block in the hierarchy.
    if (OFF_DEB_SMPLS < 1 || OFF_DEB_SMPLS > 15) begin : g_off_deb_smpls_out_of_range
    end

    state_t          state_q;
    state_t          state_nxt;
    logic [LC_W-1:0] lft_q;
    logic [LC_W-1:0] rght_q;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_nxt;

    logic [LC_W:0]   sum;
    logic [LC_W-1:0] diff;
    logic [LC_W+1:0] diff_x4;
    logic [LC_W+4:0] diff_x16;
    logic [LC_W+4:0] sum_x15;
    logic            sum_gt_min;
    logic            sum_lt_min;
    logic            diff_gt_1_4;
    logic            diff_gt_15_16;
    logic            tmr_full;
    logic            step_off;

    // Sample registers: load on the strobe, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q  <= '0;
            rght_q <= '0;
        end else if (sif.ld_vld) begin
            lft_q  <= sif.lft_ld;
            rght_q <= sif.rght_ld;
        end
    end

    // Weight sum, imbalance magnitude and the threshold/ratio flags.
    always_comb begin
        sum           = {1'b0, lft_q} + {1'b0, rght_q};
        diff          = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
        diff_x4       = {diff, 2'b00};
        diff_x16      = {1'b0, diff, 4'b0000};
        sum_x15       = {sum, 4'b0000} - {4'b0000, sum};
        sum_gt_min    = (sum > SUM_HI);
        sum_lt_min    = (sum < SUM_LO);
        diff_gt_1_4   = (diff_x4 > {1'b0, sum});
        diff_gt_15_16 = (diff_x16 > sum_x15);
        tmr_full      = (tmr_q == TMR_FULL_CNT);
    end

`ifdef STEER_OFF_DEB_EN
    localparam logic [3:0] DEB_LIM = 4'(OFF_DEB_SMPLS);

    logic       vld_q;
    logic [3:0] deb_cnt_q;

    // The flag reflects the captured sample one cycle after the strobe, so the
    // strobe is delayed to line up with the sample registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= sif.ld_vld;
        end
    end

    // Consecutive step-off sample counter, live only in STEERING_EN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q <= '0;
        end else if (state_q != ST_STEERING_EN) begin
            deb_cnt_q <= '0;
        end else if (vld_q) begin
            if (!diff_gt_15_16) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q != 4'hF) begin
                deb_cnt_q <= deb_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        step_off = (deb_cnt_q >= DEB_LIM);
    end
`else
    always_comb begin
        step_off = diff_gt_15_16;
    end
`endif

    // State and stabilise-timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INITIAL;
            tmr_q   <= '0;
        end else begin
            state_q <= state_nxt;
            tmr_q   <= tmr_nxt;
        end
    end

    // Next-state and timer decode; the timer only runs while staying in STABILIZE.
    always_comb begin
        state_nxt = state_q;
        tmr_nxt   = '0;
        unique case (state_q)
            ST_INITIAL: begin
                if (sum_gt_min) begin
                    state_nxt = ST_STABILIZE;
                end
            end
            ST_STABILIZE: begin
                if (sum_lt_min) begin
                    state_nxt = ST_INITIAL;
                end else if (diff_gt_1_4) begin
                    tmr_nxt = '0;
                end else if (tmr_full) begin
                    state_nxt = ST_STEERING_EN;
                end else begin
                    tmr_nxt = tmr_q + TMR_W'(1);
                end
            end
            ST_STEERING_EN: begin
                if (sum_lt_min) begin
                    state_nxt = ST_INITIAL;
                end else if (step_off) begin
                    state_nxt = ST_STABILIZE;
                end
            end
            default: begin
                state_nxt = ST_INITIAL;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        sif.en_steer  = (state_q == ST_STEERING_EN);
        sif.rider_off = (state_q == ST_INITIAL);
        sif.state_o   = state_q;
    end

endmodule
